end_frame_encoder: RTL and testbench



---
 rtl/maple_pkg.sv | 16 +
 rtl/maple_phase_timer.sv | 25 ++
 rtl/end_frame_encoder.sv | 113 +++++++++++
 tb/tb_end_frame_encoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
// Shared Maple bus definitions: end-frame encoder state encodings and line constants
// that the transmit encoders and the receive-side detectors have to agree on.
package maple_pkg;

    typedef enum logic [4:0] {
        EFE_IDLE    = 5'b00001,
        EFE_SETUP   = 5'b00010,
        EFE_A_LOW   = 5'b00100,
        EFE_A_HIGH  = 5'b01000,
        EFE_RELEASE = 5'b10000
    } efe_state_t;

    localparam logic MAPLE_LINE_IDLE    = 1'b1;
    localparam int   MAPLE_END_A_PULSES = 2;

endpackage

// File: rtl/maple_phase_timer.sv
// Line-phase timer shared by the Maple frame encoders: counts clk cycles within a
// phase and flags the last cycle of the phase.
module maple_phase_timer #(
    parameter int PHASE_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic phase_end
);

    logic [CNT_W-1:0] timer;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign phase_end = (timer == CNT_W'(PHASE_CYCLES - 1));

endmodule

// File: rtl/end_frame_encoder.sv
// Maple bus end-of-frame generator: SDCKB falls, SDCKA pulses low A_PULSES times,
// then SDCKB rises, each step lasting PHASE_CYCLES clocks.
module end_frame_encoder
    import maple_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int A_PULSES     = MAPLE_END_A_PULSES,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic sdcka_out,
    output logic sdckb_out,
    output logic drive_en,
    output logic busy,
    output logic done
);

    localparam logic [3:0] PULSE_TARGET = 4'(A_PULSES);

    efe_state_t state;
    efe_state_t next_state;
    logic [3:0] pulse_cnt;
    logic       phase_end;
    logic       timer_clear;
    logic       pulse_inc;
    logic       sdcka_d;
    logic       sdckb_d;
    logic       active_d;
    logic       done_d;

    maple_phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (timer_clear),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EFE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are decoded from next_state and registered, so the lines change on
    // the same edge the state does.
    always_comb begin
        next_state = state;
        pulse_inc  = 1'b0;
        unique case (state)
            EFE_IDLE: begin
                if (start) next_state = EFE_SETUP;
            end
            EFE_SETUP: begin
                if (phase_end) next_state = EFE_A_LOW;
            end
            EFE_A_LOW: begin
                if (phase_end) begin
                    next_state = EFE_A_HIGH;
                    pulse_inc  = 1'b1;
                end
            end
            EFE_A_HIGH: begin
                if (phase_end) begin
                    next_state = (pulse_cnt < PULSE_TARGET) ? EFE_A_LOW : EFE_RELEASE;
                end
            end
            EFE_RELEASE: begin
                if (phase_end) next_state = EFE_IDLE;
            end
            default: next_state = EFE_IDLE;
        endcase

        timer_clear = (next_state != state) || (state == EFE_IDLE);
        sdcka_d     = (next_state == EFE_A_LOW) ? ~MAPLE_LINE_IDLE : MAPLE_LINE_IDLE;
        sdckb_d     = (next_state == EFE_IDLE || next_state == EFE_RELEASE)
                      ? MAPLE_LINE_IDLE : ~MAPLE_LINE_IDLE;
        active_d    = (next_state != EFE_IDLE);
        done_d      = (state == EFE_RELEASE) && (next_state == EFE_IDLE);
    end

    // Pulse count restarts with every pattern and saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset || state == EFE_IDLE) begin
            pulse_cnt <= '0;
        end else if (pulse_inc && pulse_cnt != 4'hF) begin
            pulse_cnt <= pulse_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sdcka_out <= MAPLE_LINE_IDLE;
            sdckb_out <= MAPLE_LINE_IDLE;
            drive_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            sdcka_out <= sdcka_d;
            sdckb_out <= sdckb_d;
            drive_en  <= active_d;
            busy      <= active_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_end_frame_encoder.sv
// Self-checking bench for end_frame_encoder: defaults, A_PULSES=3 and PHASE_CYCLES=1
// instances, with an end-frame detector watching the lines.
module tb_end_frame_encoder;
    import maple_pkg::*;

    localparam int RUN_LEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0 = 1'b0, start0 = 1'b0, a0, b0, en0, busy0, done0;
    logic reset1 = 1'b0, start1 = 1'b0, a1, b1, en1, busy1, done1;
    logic reset2 = 1'b0, start2 = 1'b0, a2, b2, en2, busy2, done2;

    end_frame_encoder #(.PHASE_CYCLES(4), .A_PULSES(2), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset0), .start(start0), .sdcka_out(a0), .sdckb_out(b0),
        .drive_en(en0), .busy(busy0), .done(done0));

    end_frame_encoder #(.PHASE_CYCLES(4), .A_PULSES(3), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .sdcka_out(a1), .sdckb_out(b1),
        .drive_en(en1), .busy(busy1), .done(done1));

    end_frame_encoder #(.PHASE_CYCLES(1), .A_PULSES(2), .CNT_W(8)) dut2 (
        .clk(clk), .reset(reset2), .start(start2), .sdcka_out(a2), .sdckb_out(b2),
        .drive_en(en2), .busy(busy2), .done(done2));

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        string name;
        int    restart_a;
        int    restart_b;
        int    reset_at;
        int    exp_busy;
        int    exp_b_low;
        int    exp_a_falls;
        int    exp_dones;
    } scen_t;

    scen_t scen[4];

    // Line-receive end-frame detector for the two P=4 instances.
    int   ef0_ok = 0, ef0_err = 0, falls0 = 0;
    int   ef1_ok = 0, ef1_err = 0, falls1 = 0;
    logic pa0 = 1'b1, pb0 = 1'b1, pa1 = 1'b1, pb1 = 1'b1;

    always @(negedge clk) begin
        pa0 <= a0;
        pb0 <= b0;
        if (pb0 && !b0) falls0 <= 0;
        else if (!b0 && pa0 && !a0) falls0 <= falls0 + 1;
        if (!pb0 && b0) begin
            if (falls0 == MAPLE_END_A_PULSES) ef0_ok <= ef0_ok + 1;
            else ef0_err <= ef0_err + 1;
        end
    end

    always @(negedge clk) begin
        pa1 <= a1;
        pb1 <= b1;
        if (pb1 && !b1) falls1 <= 0;
        else if (!b1 && pa1 && !a1) falls1 <= falls1 + 1;
        if (!pb1 && b1) begin
            if (falls1 == MAPLE_END_A_PULSES) ef1_ok <= ef1_ok + 1;
            else ef1_err <= ef1_err + 1;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Expected {sdcka, sdckb, drive_en, busy, done} in cycle t after a start sampled
    // at the end of cycle 0.
    function automatic logic [4:0] expected_at(input int t, input int phase_cycles,
                                               input int a_pulses, input int reset_at);
        int busy_len;
        int ph;
        busy_len = (2 + 2 * a_pulses) * phase_cycles;
        if (reset_at >= 0 && t > reset_at) return 5'b11000;
        if (t >= 1 && t <= busy_len) begin
            ph = (t - 1) / phase_cycles;
            if (ph == 0) return 5'b10110;
            if (ph == 2 * a_pulses + 1) return 5'b11110;
            if (ph % 2 == 1) return 5'b00110;
            return 5'b10110;
        end
        if (t == busy_len + 1) return 5'b11001;
        return 5'b11000;
    endfunction

    task automatic apply_stimulus(input scen_t s);
        logic [4:0] exp_q[$];
        logic [4:0] act;
        logic [4:0] exp_v;
        logic       prev_a;
        int busy_n, blow_n, falls_n, done_n;
        busy_n = 0; blow_n = 0; falls_n = 0; done_n = 0;
        prev_a = 1'b1;
        for (int t = 0; t <= RUN_LEN; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                act   = {a0, b0, en0, busy0, done0};
                exp_v = exp_q.pop_front();
                check_output($sformatf("%s wave t=%0d", s.name, t), int'(act), int'(exp_v));
                if (busy0) busy_n++;
                if (!b0) blow_n++;
                if (prev_a && !a0) falls_n++;
                if (done0) done_n++;
                prev_a = a0;
            end else begin
                for (int k = 1; k <= RUN_LEN; k++)
                    exp_q.push_back(expected_at(k, 4, 2, s.reset_at));
            end
            start0 = (t == 0) || (t == s.restart_a) || (t == s.restart_b);
            reset0 = (t == s.reset_at) ? 1'b0 : 1'b1;
        end
        start0 = 1'b0;
        reset0 = 1'b1;
        check_output({s.name, " busy cycles"}, busy_n, s.exp_busy);
        check_output({s.name, " sdckb low cycles"}, blow_n, s.exp_b_low);
        check_output({s.name, " sdcka low pulses"}, falls_n, s.exp_a_falls);
        check_output({s.name, " done pulses"}, done_n, s.exp_dones);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ok0_snap, err0_snap, ok1_snap, err1_snap, busy1_n, busy2_n;
        int done_q[$];

        scen[0] = '{"nominal",      -1, -1, -1, 24, 20, 2, 1};
        scen[1] = '{"restart 5/12",  5, 12, -1, 24, 20, 2, 1};
        scen[2] = '{"restart 1/24",  1, 24, -1, 24, 20, 2, 1};
        scen[3] = '{"reset mid",    -1, -1, 14, 14, 14, 2, 0};

        repeat (2) @(negedge clk);
        check_output("reset state dut0", int'({a0, b0, en0, busy0, done0}), int'(5'b11000));
        check_output("reset state dut1", int'({a1, b1, en1, busy1, done1}), int'(5'b11000));
        check_output("reset state dut2", int'({a2, b2, en2, busy2, done2}), int'(5'b11000));
        reset0 = 1'b1; reset1 = 1'b1; reset2 = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) apply_stimulus(scen[i]);

        // Loopback: a valid pattern and a three-pulse pattern into the detector.
        ok0_snap = ef0_ok; err0_snap = ef0_err;
        ok1_snap = ef1_ok; err1_snap = ef1_err;
        busy1_n = 0;
        for (int t = 0; t <= 40; t++) begin
            @(negedge clk);
            if (busy1) busy1_n++;
            start0 = (t == 0);
            start1 = (t == 0);
        end
        start0 = 1'b0; start1 = 1'b0;
        check_output("loopback nominal end_frame", ef0_ok - ok0_snap, 1);
        check_output("loopback nominal end_frame_error", ef0_err - err0_snap, 0);
        check_output("loopback 3 pulses end_frame", ef1_ok - ok1_snap, 0);
        check_output("loopback 3 pulses end_frame_error", ef1_err - err1_snap, 1);
        check_output("3 pulses busy cycles", busy1_n, 32);

        // Reset and start in the same cycle: reset must win.
        @(negedge clk);
        reset0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        reset0 = 1'b1; start0 = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check_output($sformatf("reset+start idle t=%0d", t),
                         int'({a0, b0, en0, busy0, done0}), int'(5'b11000));
        end

        // PHASE_CYCLES=1 with start held through the done cycle.
        busy2_n = 0;
        for (int t = 0; t <= 20; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                if (busy2) busy2_n++;
                if (t <= 7)
                    check_output($sformatf("p1 wave t=%0d", t), int'({a2, b2, en2, busy2, done2}),
                                 int'(expected_at(t, 1, 2, -1)));
                else
                    check_output($sformatf("p1 wave t=%0d", t), int'({a2, b2, en2, busy2, done2}),
                                 int'(expected_at(t - 7, 1, 2, -1)));
                if (done2) begin
                    if (done_q.size() == 0) check_output("p1 unexpected done cycle", t, -1);
                    else check_output("p1 done cycle", t, done_q.pop_front());
                end
            end
            if (t == 0) done_q.push_back(7);
            if (t == 7) done_q.push_back(14);
            start2 = (t <= 7);
        end
        start2 = 1'b0;
        check_output("p1 busy cycles", busy2_n, 12);
        check_output("p1 done queue drained", done_q.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
